// File: rtl/fetch_reader_if.sv
// Memory-bus bundle between fetch_reader (master) and the memory (slave).
interface fetch_reader_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 32
);
  logic [AW-1:0]    mbus_addr;
  logic             mbus_ren;
  logic             mbus_wait;
  logic [WIDTH-1:0] mbus_din;

  modport master (output mbus_addr, output mbus_ren, input mbus_wait, input mbus_din);
  modport slave  (input mbus_addr, input mbus_ren, output mbus_wait, output mbus_din);
endinterface

// File: rtl/fetch_reader.sv
// Single-word memory reader: issues one bus read per start, waits out mbus_wait
// with a bounded timeout, and hands the word to a downstream register via wen.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for start
// REQ    | first bus cycle of a read (ren high)
// WAIT   | memory stalled; counting wait cycles toward TMO
// DONE   | word captured into dout; wen pulses for this cycle
// ERR    | timed out; err pulses for this cycle, dout untouched
module fetch_reader #(
  parameter int WIDTH = 32,
  parameter int AW    = 32,
  parameter int TMO   = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AW-1:0]    addr_in,
  input  logic             abort,
  output logic             busy,
  output logic [WIDTH-1:0] dout,
  output logic             wen,
  output logic             err,
  fetch_reader_if.master   mbus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] TMO_C = 8'(TMO);

  state_t           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // abort is checked first in REQ/WAIT so it beats both completion and timeout
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = addr_in;
          cnt_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!mbus.mbus_wait) begin
          dout_d  = mbus.mbus_din;
          state_d = S_DONE;
        end else begin
          cnt_d   = 8'd1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!mbus.mbus_wait) begin
          dout_d  = mbus.mbus_din;
          state_d = S_DONE;
        end else if (cnt_q == TMO_C) begin
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy           = (state_q != S_IDLE);
  assign wen            = (state_q == S_DONE);
  assign err            = (state_q == S_ERR);
  assign dout           = dout_q;
  assign mbus.mbus_ren  = (state_q == S_REQ) || (state_q == S_WAIT);
  assign mbus.mbus_addr = addr_q;

endmodule

// File: doc/fetch_reader.md
FETCH_READER -- requirements
Module: fetch_reader

Interface
REQ-001 Parameter: WIDTH, 32, data word width.
REQ-002 Parameter: AW, 32, address width.
REQ-003 Parameter: TMO, 15, maximum wait cycles before timeout; legal range 1..255.
REQ-004 Port: clk  input  1  clock; all state updates on its rising edge.
REQ-005 Port: reset  input  1  reset, synchronous, active-high.
REQ-006 Port: start  input  1  read request; sampled only in IDLE.
REQ-007 Port: addr_in  input  AW  read address; latched when start is accepted.
REQ-008 Port: abort  input  1  cancels an outstanding read.
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: mbus_addr  output  AW  memory bus address.
REQ-011 Port: mbus_ren  output  1  memory bus read enable.
REQ-012 Port: mbus_wait  input  1  memory not ready; data is valid in any REQ/WAIT cycle where it is low.
REQ-013 Port: mbus_din  input  WIDTH  memory read data.
REQ-014 Port: dout  output  WIDTH  captured word; drives the din of the downstream two-input register.
REQ-015 Port: wen  output  1  one-cycle load strobe for the downstream register.
REQ-016 Port: err  output  1  one-cycle timeout flag.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT, DONE, ERR; all outputs registered or decoded from state only.
REQ-018 IDLE: start=1 -> latch addr_in into the address register, clear the wait counter, go to REQ; start=0 -> stay in IDLE.
REQ-019 REQ and WAIT: mbus_ren=1, mbus_addr=latched address; all other states: mbus_ren=0, mbus_addr=latched address (held).
REQ-020 REQ or WAIT with mbus_wait=0 -> capture mbus_din into dout, go to DONE.
REQ-021 REQ with mbus_wait=1 -> go to WAIT, counter=1.
REQ-022 WAIT with mbus_wait=1 -> counter+1; when the counter equals TMO, go to ERR instead of incrementing.
REQ-023 DONE: wen=1 for exactly this one cycle, then go to IDLE unconditionally.
REQ-024 ERR: err=1 for exactly this one cycle, dout unchanged, wen=0, then go to IDLE.
REQ-025 abort=1 in REQ or WAIT -> go to IDLE, no capture, wen=0, err=0; abort wins over simultaneous mbus_wait=0 or timeout.
REQ-026 abort SHALL be ignored in IDLE, DONE and ERR.
REQ-027 start while busy=1 SHALL be ignored and not queued.
REQ-028 dout SHALL hold its last captured value until the next successful capture.
REQ-029 Minimum latency: start accepted at edge N; REQ during cycle N+1; with mbus_wait=0, wen=1 during cycle N+2, with dout valid in the same cycle.
REQ-030 Back-to-back reads: start asserted in the DONE cycle is ignored; start asserted in the next IDLE cycle is accepted, giving a minimum of 3 cycles per read.
REQ-031 The counter SHALL be 8 bits wide and SHALL never wrap.

Reset
REQ-032 reset=1 at a clock edge -> state IDLE, dout=0, address register=0, counter=0.
REQ-033 During reset, and in the cycle after it: busy=0, mbus_ren=0, wen=0, err=0, mbus_addr=0.
REQ-034 reset SHALL override start, abort and all bus inputs, including in the middle of a read; no wen or err pulse follows a reset.

Verification
REQ-035 Zero-wait read: start, addr_in=0x100, mbus_wait=0, mbus_din=0xDEADBEEF -> mbus_ren=1 with mbus_addr=0x100 for 1 cycle; next cycle wen=1 and dout=0xDEADBEEF.
REQ-036 Wait states: mbus_wait=1 for 3 cycles, then 0 with mbus_din=0x12345678 -> mbus_ren high for 4 cycles, then one wen pulse with dout=0x12345678, err=0.
REQ-037 Timeout, TMO=15: mbus_wait stuck at 1 -> mbus_ren high for 16 cycles, then err=1 for one cycle, wen never 1, dout keeps its previous value.
REQ-038 Abort race: in WAIT, abort=1 and mbus_wait=0 in the same cycle -> next state IDLE, no wen, dout unchanged.
REQ-039 Reset mid-read: reset asserted during WAIT -> next cycle busy=0, mbus_ren=0, dout=0; a new start afterwards completes normally.
REQ-040 Busy start: start pulses during REQ/WAIT/DONE with a different addr_in -> ignored; mbus_addr stays at the original address and exactly one wen pulse occurs.
